// File: rtl/req_ack_done_checker.sv
// req_ack_done_checker: passive multi-channel monitor for the
// bus_req -> bus_ack -> done handshake. Each channel runs its own small FSM
// with an ack window and a done window, optionally qualified by a transfer
// envelope. Errors are pulsed on err, remembered in err_code, and counted
// together with passing transactions in two saturating counters.
module req_ack_done_checker #(
  parameter int NCH      = 4,
  parameter int ACK_MAX  = 1,
  parameter int DONE_MIN = 1,
  parameter int DONE_MAX = 5,
  parameter int STRICT   = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [NCH-1:0]     bus_req,
  input  logic [NCH-1:0]     bus_ack,
  input  logic [NCH-1:0]     done,
  input  logic [NCH-1:0]     ready,
  input  logic [NCH-1:0]     transfer_envelope,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     err,
  output logic [3*NCH-1:0]   err_code,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt
);

  // Counter widths: k never exceeds ACK_MAX, j never exceeds DONE_MAX.
  localparam int KW = $clog2(ACK_MAX + 1);
  localparam int JW = $clog2(DONE_MAX + 1);
  // Wide enough to add up to NCH increments to a full counter without wrap.
  localparam int SW = CNT_W + $clog2(NCH + 1);
  localparam logic [SW-1:0] CNT_SAT = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  localparam logic [2:0] CODE_ACK_TO  = 3'd1;
  localparam logic [2:0] CODE_EARLY   = 3'd2;
  localparam logic [2:0] CODE_DONE_TO = 3'd3;
  localparam logic [2:0] CODE_ENV     = 3'd4;
  localparam logic [2:0] CODE_OVERLAP = 3'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t            state_q [NCH];
  state_t            state_d [NCH];
  logic [KW-1:0]     k_q     [NCH];
  logic [KW-1:0]     k_d     [NCH];
  logic [JW-1:0]     j_q     [NCH];
  logic [JW-1:0]     j_d     [NCH];
  logic [NCH-1:0]    env_mode_q, env_mode_d;
  logic [NCH-1:0]    req_q, req_d;
  logic [NCH-1:0]    busy_q, busy_d;
  logic [NCH-1:0]    err_q, err_d;
  logic [3*NCH-1:0]  err_code_q, err_code_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;

  logic [NCH-1:0]    req_rise;
  logic [NCH-1:0]    pass_hit;
  logic [3*NCH-1:0]  code_hit;
  logic [SW-1:0]     pass_sum;
  logic [SW-1:0]     fail_sum;

  assign req_rise = bus_req & ~req_q;
  assign req_d    = bus_req;

  // Per-channel handshake FSM: an overlapping rise (strict mode) pre-empts
  // whatever the current state would have decided this cycle.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c]       = state_q[c];
      k_d[c]           = k_q[c];
      j_d[c]           = j_q[c];
      env_mode_d[c]    = env_mode_q[c];
      pass_hit[c]      = 1'b0;
      err_d[c]         = 1'b0;
      code_hit[3*c +: 3] = 3'd0;

      if ((STRICT != 0) && req_rise[c] && (state_q[c] != IDLE)) begin
        err_d[c]           = 1'b1;
        code_hit[3*c +: 3] = CODE_OVERLAP;
        state_d[c]         = WAIT_ACK;
        k_d[c]             = KW'(1);
      end else begin
        case (state_q[c])
          IDLE: begin
            if (req_rise[c]) begin
              state_d[c] = WAIT_ACK;
              k_d[c]     = KW'(1);
            end
          end
          WAIT_ACK: begin
            if (bus_ack[c]) begin
              if (ready[c] && !transfer_envelope[c]) begin
                err_d[c]           = 1'b1;
                code_hit[3*c +: 3] = CODE_ENV;
                state_d[c]         = IDLE;
              end else begin
                state_d[c]    = WAIT_DONE;
                j_d[c]        = JW'(1);
                env_mode_d[c] = ready[c];
              end
            end else if (k_q[c] == KW'(ACK_MAX)) begin
              err_d[c]           = 1'b1;
              code_hit[3*c +: 3] = CODE_ACK_TO;
              state_d[c]         = IDLE;
            end else begin
              k_d[c] = k_q[c] + KW'(1);
            end
          end
          WAIT_DONE: begin
            if (done[c] && (j_q[c] < JW'(DONE_MIN))) begin
              err_d[c]           = 1'b1;
              code_hit[3*c +: 3] = CODE_EARLY;
              state_d[c]         = IDLE;
            end else if (done[c]) begin
              pass_hit[c] = 1'b1;
              state_d[c]  = IDLE;
            end else if (env_mode_q[c] && !transfer_envelope[c]) begin
              err_d[c]           = 1'b1;
              code_hit[3*c +: 3] = CODE_ENV;
              state_d[c]         = IDLE;
            end else if (j_q[c] == JW'(DONE_MAX)) begin
              err_d[c]           = 1'b1;
              code_hit[3*c +: 3] = CODE_DONE_TO;
              state_d[c]         = IDLE;
            end else begin
              j_d[c] = j_q[c] + JW'(1);
            end
          end
          default: begin
            state_d[c] = IDLE;
          end
        endcase
      end
    end
  end

  // busy is registered from the next state so it follows the FSM exactly.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      busy_d[c] = (state_d[c] != IDLE);
    end
  end

  // Sticky error codes: each new error overwrites its channel; clr wins.
  always_comb begin
    err_code_d = err_code_q;
    if (clr) begin
      err_code_d = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (err_d[c]) begin
          err_code_d[3*c +: 3] = code_hit[3*c +: 3];
        end
      end
    end
  end

  // Saturating pass/fail counters, summed wide and then clamped.
  always_comb begin
    pass_sum = {{(SW-CNT_W){1'b0}}, pass_cnt_q};
    fail_sum = {{(SW-CNT_W){1'b0}}, fail_cnt_q};
    for (int c = 0; c < NCH; c++) begin
      pass_sum = pass_sum + SW'(pass_hit[c]);
      fail_sum = fail_sum + SW'(err_d[c]);
    end
    pass_cnt_d = (pass_sum > CNT_SAT) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
    fail_cnt_d = (fail_sum > CNT_SAT) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
    if (clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end
  end

  // State and output registers; reset discards any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= IDLE;
        k_q[c]     <= '0;
        j_q[c]     <= '0;
      end
      env_mode_q <= '0;
      req_q      <= '0;
      busy_q     <= '0;
      err_q      <= '0;
      err_code_q <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c] <= state_d[c];
        k_q[c]     <= k_d[c];
        j_q[c]     <= j_d[c];
      end
      env_mode_q <= env_mode_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_req_ack_done_checker.sv
// Testbench for req_ack_done_checker: two instances (default lenient set and a
// strict, wider-window, 2-bit-counter set) share the same stimulus and are
// compared every cycle against a timestamp-based transaction model.
module tb_req_ack_done_checker;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst, clr;
  logic [NCH-1:0] bus_req, bus_ack, done, ready, transfer_envelope;

  logic [NCH-1:0]   busyA, errA, busyB, errB;
  logic [3*NCH-1:0] codeA, codeB;
  logic [15:0]      passA, failA;
  logic [1:0]       passB, failB;

  int assertCount = 0;
  int failCount   = 0;

  // Model configuration per instance: 0 = default set, 1 = strict set.
  int pAck    [2] = '{1, 3};
  int pDMin   [2] = '{1, 2};
  int pDMax   [2] = '{5, 5};
  int pStrict [2] = '{0, 1};
  int pSat    [2] = '{65535, 3};

  // Model state: phase 0 idle, 1 waiting for ack, 2 waiting for done.
  int now = 0;
  int phase   [2][NCH];
  int tRise   [2][NCH];
  int tAck    [2][NCH];
  bit envM    [2][NCH];
  bit reqPrev [2][NCH];
  int code    [2][NCH];
  bit expErr  [2][NCH];
  int pCnt    [2];
  int fCnt    [2];

  req_ack_done_checker #(
    .NCH(NCH), .ACK_MAX(1), .DONE_MIN(1), .DONE_MAX(5), .STRICT(0), .CNT_W(16)
  ) dutA (
    .clk(clk), .rst(rst), .clr(clr),
    .bus_req(bus_req), .bus_ack(bus_ack), .done(done), .ready(ready),
    .transfer_envelope(transfer_envelope),
    .busy(busyA), .err(errA), .err_code(codeA),
    .pass_cnt(passA), .fail_cnt(failA)
  );

  req_ack_done_checker #(
    .NCH(NCH), .ACK_MAX(3), .DONE_MIN(2), .DONE_MAX(5), .STRICT(1), .CNT_W(2)
  ) dutB (
    .clk(clk), .rst(rst), .clr(clr),
    .bus_req(bus_req), .bus_ack(bus_ack), .done(done), .ready(ready),
    .transfer_envelope(transfer_envelope),
    .busy(busyB), .err(errB), .err_code(codeB),
    .pass_cnt(passB), .fail_cnt(failB)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, now);
    end
  endtask

  // Advance the transaction model by one clock edge using the sampled inputs.
  task automatic modelStep();
    for (int m = 0; m < 2; m++) begin
      int nPass = 0;
      int nFail = 0;
      for (int c = 0; c < NCH; c++) begin
        bit rise;
        int e;
        expErr[m][c] = 1'b0;
        e = 0;
        if (rst) begin
          phase[m][c]   = 0;
          reqPrev[m][c] = 1'b0;
          code[m][c]    = 0;
          continue;
        end
        rise = bus_req[c] && !reqPrev[m][c];
        reqPrev[m][c] = bus_req[c];
        if (pStrict[m] != 0 && rise && phase[m][c] != 0) begin
          e = 5;
          phase[m][c] = 1;
          tRise[m][c] = now;
        end else if (phase[m][c] == 0) begin
          if (rise) begin
            phase[m][c] = 1;
            tRise[m][c] = now;
          end
        end else if (phase[m][c] == 1) begin
          if (bus_ack[c]) begin
            if (ready[c] && !transfer_envelope[c]) begin
              e = 4;
              phase[m][c] = 0;
            end else begin
              phase[m][c] = 2;
              tAck[m][c]  = now;
              envM[m][c]  = ready[c];
            end
          end else if (now - tRise[m][c] >= pAck[m]) begin
            e = 1;
            phase[m][c] = 0;
          end
        end else begin
          int age;
          age = now - tAck[m][c];
          if (done[c] && age < pDMin[m]) e = 2;
          else if (done[c]) nPass++;
          else if (envM[m][c] && !transfer_envelope[c]) e = 4;
          else if (age >= pDMax[m]) e = 3;
          if (done[c] || e != 0) phase[m][c] = 0;
        end
        if (e != 0) begin
          expErr[m][c] = 1'b1;
          nFail++;
          if (!clr) code[m][c] = e;
        end
        if (clr) code[m][c] = 0;
      end
      if (rst || clr) begin
        pCnt[m] = 0;
        fCnt[m] = 0;
      end else begin
        pCnt[m] = (pCnt[m] + nPass > pSat[m]) ? pSat[m] : pCnt[m] + nPass;
        fCnt[m] = (fCnt[m] + nFail > pSat[m]) ? pSat[m] : fCnt[m] + nFail;
      end
    end
    now++;
  endtask

  // Compare every output of both instances against the model.
  task automatic compareAll();
    logic [NCH-1:0]   eBusy [2];
    logic [NCH-1:0]   eErr  [2];
    logic [3*NCH-1:0] eCode [2];
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) begin
        eBusy[m][c]        = (phase[m][c] != 0);
        eErr[m][c]         = expErr[m][c];
        eCode[m][3*c +: 3] = 3'(code[m][c]);
      end
    end
    checkOutput("busyA", 64'(busyA), 64'(eBusy[0]));
    checkOutput("errA",  64'(errA),  64'(eErr[0]));
    checkOutput("codeA", 64'(codeA), 64'(eCode[0]));
    checkOutput("passA", 64'(passA), 64'(pCnt[0]));
    checkOutput("failA", 64'(failA), 64'(fCnt[0]));
    checkOutput("busyB", 64'(busyB), 64'(eBusy[1]));
    checkOutput("errB",  64'(errB),  64'(eErr[1]));
    checkOutput("codeB", 64'(codeB), 64'(eCode[1]));
    checkOutput("passB", 64'(passB), 64'(pCnt[1]));
    checkOutput("failB", 64'(failB), 64'(fCnt[1]));
  endtask

  // Drive one cycle of inputs on the falling edge, then step and check.
  task automatic applyStimulus(input logic [NCH-1:0] rq, input logic [NCH-1:0] ak,
                               input logic [NCH-1:0] dn, input logic [NCH-1:0] rd,
                               input logic [NCH-1:0] ev, input logic cl, input logic rs);
    @(negedge clk);
    bus_req = rq; bus_ack = ak; done = dn; ready = rd;
    transfer_envelope = ev; clr = cl; rst = rs;
    @(posedge clk);
    modelStep();
    #1;
    compareAll();
  endtask

  // Directed handshakes from the test plan, then a long randomized run.
  initial begin
    bus_req = '0; bus_ack = '0; done = '0; ready = '0;
    transfer_envelope = '0; clr = 1'b0; rst = 1'b1;

    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b1);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // All channels pass in the same cycle (saturates the 2-bit counter).
    applyStimulus('1, '0, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '1, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '0, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '0, '1, '0, '1, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Same again with clr in the passing cycle.
    applyStimulus('1, '0, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '1, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '0, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '0, '1, '0, '1, 1'b1, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Ack never arrives: ACK_TO on both instances at their own windows.
    applyStimulus(4'b0001, '0, '0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, '0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Envelope mode: envelope drops one cycle after ack -> ENV.
    applyStimulus(4'b0010, '0, '0, '0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0010, '0, 4'b0010, 4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, '0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0);

    // Second rise during WAIT_DONE: OVERLAP in strict mode, ignored otherwise.
    applyStimulus(4'b0100, '0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 4'b0100, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0000, '0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0100, '0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(4'b0100, '0, 4'b0100, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Reset while in WAIT_DONE discards the transaction.
    applyStimulus('1, '0, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '1, '0, '0, '1, 1'b0, 1'b0);
    applyStimulus('1, '0, '0, '0, '1, 1'b0, 1'b1);
    applyStimulus('0, '0, '0, '0, '0, 1'b0, 1'b0);

    // Randomized traffic with varying request density.
    for (int i = 0; i < 4000; i++) begin
      int pct;
      logic [NCH-1:0] rq, ak, dn, rd, ev;
      case ((i / 400) % 3)
        0:       pct = 50;
        1:       pct = 12;
        default: pct = 5;
      endcase
      for (int c = 0; c < NCH; c++) begin
        rq[c] = ($urandom_range(0, 99) < pct);
        ak[c] = ($urandom_range(0, 99) < 50);
        dn[c] = ($urandom_range(0, 99) < 35);
        rd[c] = ($urandom_range(0, 99) < 50);
        ev[c] = ($urandom_range(0, 99) < 90);
      end
      applyStimulus(rq, ak, dn, rd, ev,
                    1'($urandom_range(0, 79) == 0),
                    1'($urandom_range(0, 299) == 0));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
